seq_mult4: RTL and testbench

- Sequential shift-and-add unsigned multiplier.
- Sits directly downstream of the team's ripple-carry adder datapath and consumes its sum/carry every iteration.
- Takes two WIDTH-bit operands under a start/busy/done handshake and returns a 2*WIDTH-bit product after WIDTH iteration cycles.
- Feeds the arithmetic result bus of the lab datapath.

---
 rtl/seq_mult4_pkg.sv | 25 ++
 rtl/seq_mult4_rca_nbit.sv | 55 +++++
 rtl/seq_mult4.sv | 130 +++++++++++++
 tb/tb_seq_mult4.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_mult4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult4_pkg
// Purpose  : Shared definitions for the sequential shift-and-add multiplier.
//            Holds the default operand width and the controller state
//            encoding. Encoding 2'd3 is unused; the controller maps it to
//            IDLE.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult4_pkg;

  // Default operand width. The product is twice this width.
  localparam int unsigned SEQ_MULT4_WIDTH = 4;

  // Controller states. The encoding is fixed so that it stays stable across
  // tools and debug views.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : seq_mult4_pkg
`default_nettype wire

// File: rtl/seq_mult4_rca_nbit.sv
`default_nettype none
// ============================================================================
// Module   : fa_cell / rca_nbit
// Purpose  : fa_cell is the 1-bit full-adder cell. rca_nbit chains WIDTH of
//            these cells into a ripple-carry adder. The adder is purely
//            combinational.
// Ports    : A    [WIDTH-1:0] in  - addend
//            B    [WIDTH-1:0] in  - addend
//            cin              in  - carry in
//            S    [WIDTH-1:0] out - sum
//            cout             out - carry out of the MSB
// Revision : 1.0 - initial release
// ============================================================================
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule : fa_cell

module rca_nbit
  import seq_mult4_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT4_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] S
);

  // w_carry[i] is the carry into bit i. w_carry[WIDTH] is the final carry out.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    fa_cell u_fa (
      .a  (A[gi]),
      .b  (B[gi]),
      .ci (w_carry[gi]),
      .s  (S[gi]),
      .co (w_carry[gi+1])
    );
  end

  assign cout = w_carry[WIDTH];

endmodule : rca_nbit
`default_nettype wire

// File: rtl/seq_mult4.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult4
// Purpose  : Sequential unsigned shift-and-add multiplier. It accepts A and B
//            on a start edge in IDLE and runs WIDTH iterations. It then
//            presents the 2*WIDTH-bit product on P and pulses done for one
//            cycle.
// Ports    : clk                in  - system clock, rising edge
//            rst                in  - asynchronous active-high reset
//            start              in  - job request, sampled only in IDLE
//            A     [WIDTH-1:0]  in  - multiplicand, captured on accept edge
//            B     [WIDTH-1:0]  in  - multiplier, captured on accept edge
//            busy               out - high while state != IDLE
//            done               out - one-cycle pulse, P valid from then on
//            P     [2*WIDTH-1:0] out - registered product
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult4
  import seq_mult4_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MULT4_WIDTH,
  parameter int unsigned CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_q,  state_d;
  logic [WIDTH-1:0]     mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mult_q,   mult_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   p_q,      p_d;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_acc_next;
  logic [WIDTH-1:0]     w_mult_next;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign w_addend = mult_q[0] ? mcand_q : '0;

  rca_nbit #(
    .WIDTH (WIDTH)
  ) u_rca (
    .A    (acc_hi_q),
    .B    (w_addend),
    .cin  (1'b0),
    .cout (w_cout),
    .S    (w_sum)
  );

  // The expression {cout,sum,mult} >> 1 is written out field by field.
  // The consumed multiplier LSB drops off the bottom, and the sum LSB moves
  // into the multiplier MSB.
  assign w_acc_next  = {w_cout, w_sum[WIDTH-1:1]};
  assign w_mult_next = {w_sum[0], mult_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mult_d   = mult_q;
    acc_hi_d = acc_hi_q;
    cnt_d    = cnt_q;
    p_d      = p_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = A;
          mult_d   = B;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_hi_d = w_acc_next;
        mult_d   = w_mult_next;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          p_d     = {w_acc_next, w_mult_next};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Unused encoding: fall back to a safe idle state.
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mult_q   <= '0;
      acc_hi_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mult_q   <= mult_d;
      acc_hi_q <= acc_hi_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign P    = p_q;

endmodule : seq_mult4
`default_nettype wire

// File: tb/tb_seq_mult4.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult4
// Purpose  : Self-checking bench for seq_mult4. Expected products come from
//            plain integer multiplication. Expected timing comes from the
//            handshake rules: busy one edge after accept, done WIDTH edges
//            after accept, and IDLE on the following edge.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult4;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MAX_WAIT = 20;

  logic               clk;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;

  int n_checks;
  int n_fails;

  seq_mult4 #(
    .WIDTH (WIDTH),
    .CNT_W (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job. Inputs are driven #1 after an edge. Outputs are sampled
  // #1 after the following edges.
  // When noisy=1, A, B and start are randomised during RUN and DONE.
  // With quick=1, the task leaves right after the return to IDLE, so that
  // the caller can re-assert start straight away.
  task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit noisy, input bit quick, input string tag);
    int unsigned exp_p;
    int          n;
    int          pulses;
    exp_p  = int'(a) * int'(b);
    A      = a;
    B      = b;
    start  = 1'b1;
    @(posedge clk); #1;            // accept edge k
    start  = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, "_done_after_accept"}, 32'(done), 32'd0);
    n      = 0;
    pulses = 0;
    while (n < int'(MAX_WAIT)) begin
      if (noisy) begin
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        start = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check({tag, "_done_latency"}, 32'(n), 32'(WIDTH));
    check({tag, "_product"}, 32'(P), exp_p);
    if (noisy) begin
      A     = WIDTH'($urandom);
      B     = WIDTH'($urandom);
      start = 1'b1;
    end
    @(posedge clk); #1;            // DONE -> IDLE
    start = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    if (!quick) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (done) pulses++;
      end
      check({tag, "_extra_done"}, 32'(pulses), 32'd0);
      check({tag, "_p_hold"}, 32'(P), exp_p);
      check({tag, "_stay_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_p", 32'(P), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(busy), 32'd0);

    run_job(4'd3,  4'd5,  1'b0, 1'b0, "j3x5");
    run_job(4'd15, 4'd15, 1'b0, 1'b0, "j15x15");
    run_job(4'd0,  4'd9,  1'b0, 1'b0, "j0x9");
    run_job(4'd9,  4'd0,  1'b0, 1'b0, "j9x0");
    run_job(4'd2,  4'd7,  1'b1, 1'b0, "j2x7_noisy");
    run_job(4'd6,  4'd6,  1'b0, 1'b0, "j6x6");

    // Abort a running job with an asynchronous reset between edges.
    A     = 4'd13;
    B     = 4'd11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p", 32'(P), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < int'(WIDTH) + 2; i++) begin
        @(posedge clk); #1;
        if (done || busy) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
    end
    run_job(4'd4, 4'd4, 1'b0, 1'b0, "j4x4_after_abort");

    // Random jobs, some of them with noisy inputs.
    for (int i = 0; i < 20; i++) begin
      run_job(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, "rand");
    end

    // Exhaustive sweep, back to back: start is re-asserted in IDLE.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_job(WIDTH'(a), WIDTH'(b), 1'b0, 1'b1, "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_seq_mult4
`default_nettype wire
